// File: rtl/logic_sweep_eval_if.sv
// Bundled control, LUT and result signals of the truth-table sweeper.
`timescale 1ns/1ps
interface logic_sweep_eval_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic                   cmp_en;
  logic [(1<<N_IN)-1:0]   lut_dut;
  logic [(1<<N_IN)-1:0]   lut_ref;
  logic                   busy;
  logic [N_IN-1:0]        vec_o;
  logic                   out_o;
  logic                   exp_o;
  logic                   vec_valid;
  logic                   mismatch_o;
  logic [N_IN:0]          ones_cnt;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_err_vec;
  logic                   first_err_valid;
  logic                   done;

  modport master (
    output start, cmp_en, lut_dut, lut_ref,
    input  busy, vec_o, out_o, exp_o, vec_valid, mismatch_o,
           ones_cnt, err_cnt, first_err_vec, first_err_valid, done
  );

  modport slave (
    input  start, cmp_en, lut_dut, lut_ref,
    output busy, vec_o, out_o, exp_o, vec_valid, mismatch_o,
           ones_cnt, err_cnt, first_err_vec, first_err_valid, done
  );
endinterface

// File: rtl/logic_sweep_eval.sv
// Exhaustive truth-table sweeper: walks every input vector of an N_IN-input LUT,
// holds each for HOLD_CYCLES clocks, and tallies ones, mismatches and the first failure.
`timescale 1ns/1ps
module logic_sweep_eval #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_sweep_eval_if.slave sw
);
  localparam int NV = 1 << N_IN;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN:0] IDX_LAST  = (N_IN+1)'(NV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [N_IN:0]   idx, idx_n;
  logic [HW-1:0]   hold, hold_n;
  logic            take;
  logic [NV-1:0]   cap_dut, cap_ref, dut_n, ref_n;
  logic            cap_cmp, cmp_n;
  logic            run_n;
  logic [N_IN-1:0] vsel_n;

  logic            busy_q, out_q, exp_q, vv_q, mm_q, done_q, fevv_q;
  logic [N_IN-1:0] vec_q, fev_q;
  logic [N_IN:0]   ones_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold;
    take    = 1'b0;
    case (state)
      IDLE: if (sw.start) begin
        state_n = RUN;
        idx_n   = '0;
        hold_n  = '0;
        take    = 1'b1;
      end
      RUN: begin
        if (hold == HOLD_LAST) begin
          hold_n = '0;
          if (idx == IDX_LAST) state_n = DONE;
          else                 idx_n   = idx + (N_IN+1)'(1);
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so vector 0 shows right after start.
  assign dut_n  = take ? sw.lut_dut : cap_dut;
  assign ref_n  = take ? sw.lut_ref : cap_ref;
  assign cmp_n  = take ? sw.cmp_en  : cap_cmp;
  assign run_n  = (state_n == RUN);
  assign vsel_n = idx_n[N_IN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dut <= '0;
      cap_ref <= '0;
      cap_cmp <= 1'b0;
      busy_q  <= 1'b0;
      vec_q   <= '0;
      out_q   <= 1'b0;
      exp_q   <= 1'b0;
      vv_q    <= 1'b0;
      mm_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cap_dut <= dut_n;
      cap_ref <= ref_n;
      cap_cmp <= cmp_n;
      busy_q  <= run_n;
      vec_q   <= run_n ? vsel_n : '0;
      out_q   <= run_n & dut_n[vsel_n];
      exp_q   <= run_n & ref_n[vsel_n];
      vv_q    <= run_n & (hold_n == '0);
      mm_q    <= run_n & cmp_n & (dut_n[vsel_n] ^ ref_n[vsel_n]);
      done_q  <= (state_n == DONE);
    end
  end

  // Tallies advance once per vector, on its vec_valid cycle, and survive until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      err_q  <= '0;
      fev_q  <= '0;
      fevv_q <= 1'b0;
    end else if (take) begin
      ones_q <= '0;
      err_q  <= '0;
      fev_q  <= '0;
      fevv_q <= 1'b0;
    end else if (vv_q) begin
      ones_q <= ones_q + {{N_IN{1'b0}}, out_q};
      if (mm_q) begin
        err_q <= err_q + (N_IN+1)'(1);
        if (!fevv_q) begin
          fev_q  <= vec_q;
          fevv_q <= 1'b1;
        end
      end
    end
  end

  assign sw.busy            = busy_q;
  assign sw.vec_o           = vec_q;
  assign sw.out_o           = out_q;
  assign sw.exp_o           = exp_q;
  assign sw.vec_valid       = vv_q;
  assign sw.mismatch_o      = mm_q;
  assign sw.ones_cnt        = ones_q;
  assign sw.err_cnt         = err_q;
  assign sw.first_err_vec   = fev_q;
  assign sw.first_err_valid = fevv_q;
  assign sw.done            = done_q;
endmodule
